// File: rtl/load_store_unit.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// Module   : load_store_unit
// Purpose  : MEM-stage data-memory initiator; issues one load/store, waits on
//            mem_busy, extracts/extends load data. Option: LSU_MISALIGN_TRAP_EN
// Revision : 1.0
// ============================================================================
module load_store_unit #(
    parameter int TIMEOUT_CYCLES = 16
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        flush,
    input  logic        req_valid,
    input  logic        req_load,
    input  logic        req_store,
    input  logic [2:0]  req_funct3,
    input  logic [31:0] req_addr,
    input  logic [31:0] req_wdata,
    input  logic [4:0]  req_rd,
    output logic        mem_read_en,
    output logic        mem_write_en,
    output logic [31:0] ram_address,
    output logic [31:0] data_in,
    output logic [2:0]  load_type,
    output logic [2:0]  store_type,
    input  logic [31:0] data_out,
    input  logic        mem_busy,
    output logic        stall,
    output logic        wb_valid,
    output logic [31:0] wb_data,
    output logic [4:0]  wb_rd,
    output logic        lsu_exc,
    output logic [1:0]  lsu_exc_cause
);

    localparam int              CW        = $clog2(TIMEOUT_CYCLES + 1);
    localparam logic [CW-1:0]   c_TO_LAST = CW'(TIMEOUT_CYCLES - 1);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_REQ  = 2'd1,
        S_WAIT = 2'd2,
        S_DONE = 2'd3
    } state_t;

    state_t        r_state;
    state_t        w_state_nxt;

    logic [31:0]   r_addr;
    logic [31:0]   r_wdata;
    logic [31:0]   r_wb_data;
    logic [2:0]    r_funct3;
    logic [2:0]    r_store_type;
    logic [4:0]    r_rd;
    logic          r_is_load;
    logic          r_supported;
    logic          r_dead;
    logic          r_exc;
    logic [1:0]    r_cause;
    logic [CW-1:0] r_cnt;

    logic          w_access;
    logic          w_supp_in;
    logic          w_misalign;
    logic          w_capture;
    logic          w_tout;
    logic [7:0]    w_byte;
    logic [15:0]   w_half;
    logic [31:0]   w_ext;

    assign w_access = req_valid && (req_load || req_store) && !flush;

    always_comb begin
        w_supp_in = 1'b0;
        if (req_load) begin
            case (req_funct3)
                3'b000, 3'b001, 3'b010, 3'b100, 3'b101: w_supp_in = 1'b1;
                default:                                w_supp_in = 1'b0;
            endcase
        end else begin
            w_supp_in = (req_funct3 <= 3'b010);
        end
    end

`ifdef LSU_MISALIGN_TRAP_EN
    assign w_misalign = w_supp_in &&
                        (((req_funct3[1:0] == 2'b01) && req_addr[0]) ||
                         ((req_funct3[1:0] == 2'b10) && (req_addr[1:0] != 2'b00)));
`else
    assign w_misalign = 1'b0;
`endif

    // Lane extraction works on the full word returned by the memory.
    always_comb begin
        w_byte = data_out[7:0];
        case (r_addr[1:0])
            2'd0:    w_byte = data_out[7:0];
            2'd1:    w_byte = data_out[15:8];
            2'd2:    w_byte = data_out[23:16];
            default: w_byte = data_out[31:24];
        endcase
        w_half = r_addr[1] ? data_out[31:16] : data_out[15:0];
        case (r_funct3)
            3'b000:  w_ext = {{24{w_byte[7]}}, w_byte};
            3'b001:  w_ext = {{16{w_half[15]}}, w_half};
            3'b100:  w_ext = {24'd0, w_byte};
            3'b101:  w_ext = {16'd0, w_half};
            default: w_ext = data_out;
        endcase
    end

    always_comb begin
        w_state_nxt = r_state;
        w_capture   = 1'b0;
        w_tout      = 1'b0;
        case (r_state)
            S_IDLE: begin
                if (w_access) begin
                    w_state_nxt = w_misalign ? S_DONE : S_REQ;
                end
            end
            S_REQ: begin
                w_state_nxt = S_WAIT;
            end
            S_WAIT: begin
                // The first WAIT cycle never samples mem_busy.
                if ((r_cnt != '0) && !mem_busy) begin
                    w_capture   = 1'b1;
                    w_state_nxt = S_DONE;
                end else if (r_cnt == c_TO_LAST) begin
                    w_tout      = 1'b1;
                    w_state_nxt = S_DONE;
                end
            end
            default: begin
                w_state_nxt = S_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_state      <= S_IDLE;
            r_addr       <= '0;
            r_wdata      <= '0;
            r_wb_data    <= '0;
            r_funct3     <= 3'b000;
            r_store_type <= 3'b010;
            r_rd         <= '0;
            r_is_load    <= 1'b0;
            r_supported  <= 1'b0;
            r_dead       <= 1'b0;
            r_exc        <= 1'b0;
            r_cause      <= 2'b00;
            r_cnt        <= '0;
        end else begin
            r_state <= w_state_nxt;
            case (r_state)
                S_IDLE: begin
                    r_dead  <= 1'b0;
                    r_exc   <= 1'b0;
                    r_cause <= 2'b00;
                    if (w_access) begin
                        r_addr      <= req_addr;
                        r_wdata     <= req_wdata;
                        r_funct3    <= req_funct3;
                        r_rd        <= req_rd;
                        r_is_load   <= req_load;
                        r_supported <= w_supp_in;
                        r_cnt       <= '0;
                        if (!req_load) begin
                            r_store_type <= req_funct3;
                        end
                        if (w_misalign) begin
                            r_exc   <= 1'b1;
                            r_cause <= req_load ? 2'b01 : 2'b10;
                        end
                    end
                end
                S_REQ: begin
                    if (flush) begin
                        r_dead <= 1'b1;
                    end
                end
                S_WAIT: begin
                    r_cnt <= r_cnt + CW'(1);
                    if (flush) begin
                        r_dead <= 1'b1;
                    end
                    if (w_capture) begin
                        r_wb_data <= w_ext;
                    end
                    // Unsupported accesses never strobed, so they cannot time out.
                    if (w_tout && r_supported) begin
                        r_exc   <= 1'b1;
                        r_cause <= 2'b11;
                    end
                end
                default: begin
                end
            endcase
        end
    end

    assign stall         = !reset && (((r_state == S_IDLE) && w_access) ||
                                      (r_state == S_REQ) || (r_state == S_WAIT));
    assign mem_read_en   = (r_state == S_REQ) && r_supported && r_is_load;
    assign mem_write_en  = (r_state == S_REQ) && r_supported && !r_is_load;
    assign ram_address   = r_addr;
    assign data_in       = r_wdata;
    assign load_type     = 3'b010;
    assign store_type    = r_store_type;
    assign wb_valid      = (r_state == S_DONE) && r_is_load && r_supported &&
                           !r_exc && !r_dead && !flush;
    assign wb_data       = r_wb_data;
    assign wb_rd         = r_rd;
    assign lsu_exc       = (r_state == S_DONE) && r_exc;
    assign lsu_exc_cause = lsu_exc ? r_cause : 2'b00;

endmodule
`default_nettype wire

// File: tb/tb_load_store_unit.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// Module   : tb_load_store_unit
// Purpose  : Directed bench for load_store_unit with a transaction-level model
// Revision : 1.0
// ============================================================================
module tb_load_store_unit;

    localparam int TO = 16;

    logic        clk = 1'b0;
    logic        reset;
    logic        flush;
    logic        req_valid;
    logic        req_load;
    logic        req_store;
    logic [2:0]  req_funct3;
    logic [31:0] req_addr;
    logic [31:0] req_wdata;
    logic [4:0]  req_rd;
    logic        mem_read_en;
    logic        mem_write_en;
    logic [31:0] ram_address;
    logic [31:0] data_in;
    logic [2:0]  load_type;
    logic [2:0]  store_type;
    logic [31:0] data_out;
    logic        mem_busy;
    logic        stall;
    logic        wb_valid;
    logic [31:0] wb_data;
    logic [4:0]  wb_rd;
    logic        lsu_exc;
    logic [1:0]  lsu_exc_cause;

    int checks  = 0;
    int errors  = 0;
    int cyc     = 0;
    int n_issue = 0;
    int busy_len = 1;
    int busy_cnt;
    logic [31:0] mem [0:255];

    load_store_unit #(.TIMEOUT_CYCLES(TO)) dut (
        .clk(clk), .reset(reset), .flush(flush),
        .req_valid(req_valid), .req_load(req_load), .req_store(req_store),
        .req_funct3(req_funct3), .req_addr(req_addr), .req_wdata(req_wdata),
        .req_rd(req_rd), .mem_read_en(mem_read_en), .mem_write_en(mem_write_en),
        .ram_address(ram_address), .data_in(data_in), .load_type(load_type),
        .store_type(store_type), .data_out(data_out), .mem_busy(mem_busy),
        .stall(stall), .wb_valid(wb_valid), .wb_data(wb_data), .wb_rd(wb_rd),
        .lsu_exc(lsu_exc), .lsu_exc_cause(lsu_exc_cause)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string nm, input logic [31:0] a, input logic [31:0] e);
        checks++;
        if (a !== e) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", nm, a, e, cyc);
        end
    endtask

    function automatic logic [31:0] place(input logic [31:0] old, input logic [31:0] a,
                                          input logic [2:0] f, input logic [31:0] d);
        logic [31:0] m;
        logic [31:0] v;
        int          sh;
        case (f)
            3'b000: begin sh = int'(a[1:0]) * 8; m = 32'hFF << sh;   v = (d & 32'hFF) << sh;   end
            3'b001: begin sh = int'(a[1]) * 16;  m = 32'hFFFF << sh; v = (d & 32'hFFFF) << sh; end
            default: begin m = 32'hFFFF_FFFF; v = d; end
        endcase
        return (old & ~m) | (v & m);
    endfunction

    function automatic logic [31:0] ext(input logic [31:0] w, input logic [31:0] a,
                                        input logic [2:0] f);
        logic [31:0] b;
        logic [31:0] h;
        b = (w >> (int'(a[1:0]) * 8)) & 32'hFF;
        h = (w >> (int'(a[1]) * 16)) & 32'hFFFF;
        case (f)
            3'b000:  return b[7]  ? (b | 32'hFFFF_FF00) : b;
            3'b001:  return h[15] ? (h | 32'hFFFF_0000) : h;
            3'b100:  return b;
            3'b101:  return h;
            default: return w;
        endcase
    endfunction

    // Data memory: registered read word, mem_busy high for busy_len cycles after a strobe.
    always @(posedge clk) begin
        if (reset) begin
            busy_cnt <= 0;
            data_out <= '0;
            for (int i = 0; i < 256; i++) mem[i] <= '0;
        end else begin
            if (mem_read_en) data_out <= mem[ram_address[9:2]];
            if (mem_write_en)
                mem[ram_address[9:2]] <= place(mem[ram_address[9:2]], ram_address, store_type, data_in);
            if (mem_read_en || mem_write_en) busy_cnt <= busy_len;
            else if (busy_cnt != 0)          busy_cnt <= busy_cnt - 1;
        end
    end
    assign mem_busy = (busy_cnt != 0);

    // Transaction-level model: per accepted access, predict strobe cycle, done cycle and results.
    initial begin : model
        logic [31:0] mm [0:255];
        bit          act, dead, e_ld, e_strobe, e_exc, e_wbv, acc, supp, mis, wbv;
        int          n0, dc, bl, k;
        logic [1:0]  e_cause;
        logic [31:0] e_addr, e_wdata, e_wb;
        logic [2:0]  e_f3;
        logic [4:0]  e_rd;
        act = 0; dead = 0; e_ld = 0; e_strobe = 0; e_exc = 0; e_wbv = 0;
        n0 = 0; dc = 0; e_cause = 0; e_addr = 0; e_wdata = 0; e_wb = 0; e_f3 = 0; e_rd = 0;
        forever begin
            @(negedge clk);
            if (reset) begin
                act = 0;
                for (int i = 0; i < 256; i++) mm[i] = '0;
                continue;
            end
            if (!act) begin
                acc = req_valid && (req_load || req_store) && !flush;
                chk("idle_stall", stall, acc);
                chk("idle_rden", mem_read_en, 0);
                chk("idle_wren", mem_write_en, 0);
                chk("idle_wbv", wb_valid, 0);
                chk("idle_exc", lsu_exc, 0);
                if (acc) begin
                    act = 1; dead = 0; n0 = cyc;
                    e_ld = req_load; e_f3 = req_funct3; e_addr = req_addr;
                    e_wdata = req_wdata; e_rd = req_rd;
                    supp = e_ld ? (e_f3 inside {3'd0, 3'd1, 3'd2, 3'd4, 3'd5}) : (e_f3 <= 3'd2);
                    mis = 0;
`ifdef LSU_MISALIGN_TRAP_EN
                    if (supp)
                        mis = ((e_f3[1:0] == 2'd1) && e_addr[0]) ||
                              ((e_f3[1:0] == 2'd2) && (e_addr[1:0] != 2'd0));
`endif
                    e_strobe = supp && !mis;
                    e_exc = 0; e_cause = 0;
                    if (mis) begin
                        dc = n0 + 1; e_exc = 1; e_cause = e_ld ? 2'd1 : 2'd2;
                    end else begin
                        bl = e_strobe ? busy_len : 0;
                        k  = (bl < 1) ? 1 : bl;
                        if (k >= TO) begin
                            dc = n0 + 2 + TO; e_exc = 1; e_cause = 2'd3;
                        end else begin
                            dc = n0 + 3 + k;
                        end
                    end
                    e_wbv = e_ld && supp && !e_exc;
                    e_wb  = ext(mm[e_addr[9:2]], e_addr, e_f3);
                    if (!e_ld && e_strobe)
                        mm[e_addr[9:2]] = place(mm[e_addr[9:2]], e_addr, e_f3, e_wdata);
                end
            end else begin
                chk("stall", stall, cyc < dc);
                chk("rden", mem_read_en, (cyc == n0 + 1) && e_strobe && e_ld);
                chk("wren", mem_write_en, (cyc == n0 + 1) && e_strobe && !e_ld);
                if ((cyc == n0 + 1) && e_strobe) begin
                    chk("addr", ram_address, e_addr);
                    chk("load_type", load_type, 3'b010);
                    if (!e_ld) begin
                        chk("data_in", data_in, e_wdata);
                        chk("store_type", store_type, e_f3);
                    end
                end
                if ((cyc > n0) && flush) dead = 1;
                wbv = (cyc == dc) && e_wbv && !dead;
                chk("wb_valid", wb_valid, wbv);
                if (wbv) begin
                    chk("wb_data", wb_data, e_wb);
                    chk("wb_rd", wb_rd, e_rd);
                end
                chk("lsu_exc", lsu_exc, (cyc == dc) && e_exc);
                if ((cyc == dc) && e_exc) chk("exc_cause", lsu_exc_cause, e_cause);
                if (cyc == dc) act = 0;
            end
        end
    end

    task automatic issue(input bit ld, input logic [2:0] f3, input logic [31:0] a,
                         input logic [31:0] wd, input logic [4:0] rd);
        req_valid = 1; req_load = ld; req_store = !ld;
        req_funct3 = f3; req_addr = a; req_wdata = wd; req_rd = rd;
        n_issue = cyc;
        @(negedge clk);
        chk("accept_stall", stall, 1);
        @(posedge clk); #1;
        req_valid = 0; req_load = 0; req_store = 0;
    endtask

    // Caller must already sit at a negedge; returns at the negedge where stall drops.
    task automatic wait_done(input int budget);
        int n;
        n = 0;
        while (stall === 1'b1 && n < budget) begin
            @(negedge clk);
            n++;
        end
        chk("done_wait", stall, 0);
    endtask

    task automatic run_load(input logic [2:0] f3, input logic [31:0] a,
                            input logic [4:0] rd, input logic [31:0] e);
        issue(1, f3, a, 32'h0, rd);
        @(negedge clk);
        chk("ld_rden", mem_read_en, 1);
        chk("ld_addr", ram_address, a);
        chk("ld_type", load_type, 3'b010);
        wait_done(30);
        chk("ld_latency", cyc - n_issue, 4);
        chk("ld_wbv", wb_valid, 1);
        chk("ld_data", wb_data, e);
        chk("ld_rd", wb_rd, rd);
        @(posedge clk); #1;
    endtask

    task automatic run_store(input logic [2:0] f3, input logic [31:0] a, input logic [31:0] wd);
        issue(0, f3, a, wd, 5'd0);
        @(negedge clk);
        chk("st_wren", mem_write_en, 1);
        chk("st_rden", mem_read_en, 0);
        chk("st_type", store_type, f3);
        chk("st_data", data_in, wd);
        chk("st_addr", ram_address, a);
        wait_done(30);
        chk("st_latency", cyc - n_issue, 4);
        chk("st_wbv", wb_valid, 0);
        @(posedge clk); #1;
    endtask

    initial begin : watchdog
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin : directed
        reset = 1; flush = 0; req_valid = 0; req_load = 0; req_store = 0;
        req_funct3 = 0; req_addr = 0; req_wdata = 0; req_rd = 0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        chk("rst_stall", stall, 0);
        chk("rst_rden", mem_read_en, 0);
        chk("rst_wren", mem_write_en, 0);
        chk("rst_wbv", wb_valid, 0);
        chk("rst_exc", lsu_exc, 0);
        chk("rst_cause", lsu_exc_cause, 0);
        chk("rst_addr", ram_address, 0);
        chk("rst_din", data_in, 0);
        chk("rst_wbdata", wb_data, 0);
        chk("rst_wbrd", wb_rd, 0);
        chk("rst_ltype", load_type, 3'b010);
        chk("rst_stype", store_type, 3'b010);
        @(posedge clk); #1;
        reset = 0;

        run_store(3'b010, 32'h100, 32'h8765_4321);
        run_load (3'b010, 32'h100, 5'd5, 32'h8765_4321);

        run_store(3'b010, 32'h100, 32'h80FF_1234);
        run_load (3'b000, 32'h103, 5'd1, 32'hFFFF_FF80);
        run_load (3'b100, 32'h103, 5'd2, 32'h0000_0080);
        run_load (3'b001, 32'h102, 5'd3, 32'hFFFF_80FF);
        run_load (3'b101, 32'h102, 5'd4, 32'h0000_80FF);

        run_store(3'b000, 32'h201, 32'h0000_00AB);
        run_load (3'b100, 32'h201, 5'd6, 32'h0000_00AB);
        run_load (3'b010, 32'h200, 5'd7, 32'h0000_AB00);

        // Unsupported load funct3: no strobe, no result, no exception.
        issue(1, 3'b011, 32'h100, 32'h0, 5'd8);
        @(negedge clk);
        chk("unsup_rden", mem_read_en, 0);
        wait_done(30);
        chk("unsup_latency", cyc - n_issue, 4);
        chk("unsup_wbv", wb_valid, 0);
        chk("unsup_exc", lsu_exc, 0);
        @(posedge clk); #1;

        // Misaligned word load.
        issue(1, 3'b010, 32'h102, 32'h0, 5'd9);
        @(negedge clk);
`ifdef LSU_MISALIGN_TRAP_EN
        chk("mis_ld_rden", mem_read_en, 0);
        chk("mis_ld_exc", lsu_exc, 1);
        chk("mis_ld_cause", lsu_exc_cause, 2'b01);
        chk("mis_ld_wbv", wb_valid, 0);
        @(posedge clk); #1;
        issue(0, 3'b001, 32'h301, 32'h5555, 5'd0);
        @(negedge clk);
        chk("mis_st_wren", mem_write_en, 0);
        chk("mis_st_exc", lsu_exc, 1);
        chk("mis_st_cause", lsu_exc_cause, 2'b10);
`else
        chk("mis_ld_rden", mem_read_en, 1);
        chk("mis_ld_addr", ram_address, 32'h102);
        wait_done(30);
        chk("mis_ld_latency", cyc - n_issue, 4);
        chk("mis_ld_wbv", wb_valid, 1);
        chk("mis_ld_data", wb_data, 32'h80FF_1234);
        chk("mis_ld_exc", lsu_exc, 0);
`endif
        @(posedge clk); #1;

        // Flush while the load is in WAIT.
        issue(1, 3'b010, 32'h100, 32'h0, 5'd10);
        @(posedge clk); #1;
        flush = 1;
        @(posedge clk); #1;
        flush = 0;
        @(negedge clk);
        wait_done(30);
        chk("flush_latency", cyc - n_issue, 4);
        chk("flush_wbv", wb_valid, 0);
        @(posedge clk); #1;

        // Bus timeout.
        busy_len = 20;
        issue(1, 3'b010, 32'h100, 32'h0, 5'd11);
        @(negedge clk);
        wait_done(40);
        chk("to_latency", cyc - n_issue, 2 + TO);
        chk("to_exc", lsu_exc, 1);
        chk("to_cause", lsu_exc_cause, 2'b11);
        chk("to_wbv", wb_valid, 0);
        @(negedge clk);
        chk("to_idle_stall", stall, 0);
        busy_len = 1;
        repeat (6) @(posedge clk);
        #1;

        // Reset while in REQ.
        issue(1, 3'b010, 32'h100, 32'h0, 5'd12);
        reset = 1;
        @(posedge clk); #1;
        reset = 0;
        @(negedge clk);
        chk("rreq_rden", mem_read_en, 0);
        chk("rreq_stall", stall, 0);
        chk("rreq_addr", ram_address, 0);
        chk("rreq_wbrd", wb_rd, 0);
        repeat (5) @(negedge clk);
        chk("rreq_wbv", wb_valid, 0);
        @(posedge clk); #1;

        run_store(3'b010, 32'h104, 32'h1357_9BDF);
        run_load (3'b001, 32'h106, 5'd13, 32'h0000_1357);
        run_load (3'b000, 32'h104, 5'd14, 32'hFFFF_FFDF);

        repeat (3) @(negedge clk);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
`default_nettype wire
